// File: rtl/misr_pkg.sv
// Shared types and helpers for the output-signature MISR compactor.
package misr_pkg;

    typedef enum logic [1:0] {IDLE, SKIP, RUN, DONE} misr_state_e;

    localparam logic [31:0] MISR_POLY32 = 32'h04C11DB7;

    // One MISR step for any width up to 64: shift, conditional feedback, inject f.
    function automatic logic [63:0] misr_step(input logic [63:0] s,
                                              input logic [63:0] poly,
                                              input logic [63:0] f,
                                              input int unsigned w);
        logic [63:0] mask;
        logic        fb;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        fb   = |(s & (64'd1 << (w - 1)));
        return ((s << 1) ^ (fb ? poly : 64'd0) ^ f) & mask;
    endfunction

endpackage

// File: rtl/misr_fold.sv
// Combinational XOR-fold of a DATA_W vector into SIG_W bits; the top chunk is zero-padded.
module misr_fold #(
    parameter int DATA_W = 412,
    parameter int SIG_W  = 32
) (
    input  logic [DATA_W-1:0] data,
    output logic [SIG_W-1:0]  f
);
    localparam int NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;

    logic [NCHUNK*SIG_W-1:0] padded;

    always_comb begin
        padded = '0;
        padded[DATA_W-1:0] = data;
        f = '0;
        for (int c = 0; c < NCHUNK; c++)
            f = f ^ padded[c*SIG_W +: SIG_W];
    end

endmodule

// File: rtl/out_sig_misr.sv
// Response compactor: skips SKIP_CYCLES valid samples after start, folds num_cycles samples into a MISR.
// Optional MISR_MASK_EN adds mask_in, ANDed with data_in before folding.
module out_sig_misr
    import misr_pkg::*;
#(
    parameter int               DATA_W      = 412,
    parameter int               SIG_W       = 32,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(MISR_POLY32),
    parameter logic [SIG_W-1:0] SEED        = '0,
    parameter int               SKIP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       num_cycles,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
`ifdef MISR_MASK_EN
    input  logic [DATA_W-1:0] mask_in,
`endif
    input  logic [SIG_W-1:0]  expected_sig,
    output logic [SIG_W-1:0]  sig,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [15:0]       sample_cnt
);
    localparam bit          NO_SKIP   = (SKIP_CYCLES == 0);
    localparam logic [15:0] SKIP_LAST = 16'(SKIP_CYCLES - 1);

    misr_state_e       state;
    logic [SIG_W-1:0]  sig_q;
    logic [SIG_W-1:0]  fold;
    logic [15:0]       cnt_q, skip_q, n_q;
    logic [DATA_W-1:0] fold_in;
    logic [63:0]       step_wide;
    logic              unused_step;
    logic              accept;

`ifdef MISR_MASK_EN
    assign fold_in = data_in & mask_in;
`else
    assign fold_in = data_in;
`endif

    misr_fold #(.DATA_W(DATA_W), .SIG_W(SIG_W)) u_fold (
        .data (fold_in),
        .f    (fold)
    );

    assign step_wide   = misr_step(64'(sig_q), 64'(POLY), 64'(fold), SIG_W);
    assign unused_step = ^(step_wide >> SIG_W);

    // start is only honoured between runs; mid-run pulses are dropped.
    assign accept = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sig_q  <= SEED;
            cnt_q  <= '0;
            skip_q <= '0;
            n_q    <= '0;
        end else if (accept) begin
            sig_q  <= SEED;
            cnt_q  <= '0;
            skip_q <= '0;
            n_q    <= num_cycles;
            if (NO_SKIP) state <= (num_cycles == 16'd0) ? DONE : RUN;
            else         state <= SKIP;
        end else if (data_valid) begin
            case (state)
                SKIP: begin
                    if (skip_q == SKIP_LAST) state <= (n_q == 16'd0) ? DONE : RUN;
                    else                     skip_q <= skip_q + 16'd1;
                end
                RUN: begin
                    sig_q <= step_wide[SIG_W-1:0];
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == n_q) state <= DONE;
                end
                default: ;
            endcase
        end
    end

    assign sig        = sig_q;
    assign sample_cnt = cnt_q;
    assign busy       = (state == SKIP) || (state == RUN);
    assign done       = (state == DONE);
    assign match      = done && (sig_q == expected_sig);

endmodule

// File: doc/out_sig_misr.md
# out_sig_misr

Downstream response compactor for the fuzz harness: consumes the DUT's flat output vector (`out_flat`) once per clock and folds it into a multiple-input signature register (MISR). One short signature then replaces the per-cycle `OUT=` trace when comparing simulators. The block sits directly after the `top` DUT instance and is driven by the same clock. It skips the reset-release cycles, compacts a programmed number of valid samples, and reports the final signature plus a match flag against an expected value.

## Interface
- `DATA_W`, 412: width of the compacted input vector (`out_flat`).
- `SIG_W`, 32: signature width; legal range 8..64.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial, SIG_W bits.
- `SEED`, 0: signature value loaded on reset and on `start`.
- `SKIP_CYCLES`, 2: valid samples discarded after `start`, before compaction.
- `clk`  in  1  sole clock, posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: load SEED and arm a run; honoured only in IDLE or DONE.
- `num_cycles`  in  16  number of samples to compact; sampled on `start`.
- `data_valid`  in  1  `data_in` is a valid sample this cycle.
- `data_in`  in  DATA_W  DUT output vector.
- `expected_sig`  in  SIG_W  golden signature; compared in DONE.
- `sig`  out  SIG_W  current signature register.
- `busy`  out  1  high in SKIP and RUN.
- `done`  out  1  high in DONE.
- `match`  out  1  `done && (sig == expected_sig)`; combinational on `expected_sig`.
- `sample_cnt`  out  16  samples compacted so far in this run.

## Operation
- **States:**
  - IDLE → SKIP on `start`.
  - SKIP → RUN after SKIP_CYCLES valid samples. SKIP_CYCLES=0 goes straight to RUN the cycle after `start`.
  - RUN → DONE when `sample_cnt` reaches the latched `num_cycles`.
  - DONE → SKIP on `start`.
  - `num_cycles`=0: SKIP exits directly to DONE with `sig`=SEED.
- **Fold:** split `data_in` into SIG_W-bit chunks, chunk 0 = bits [SIG_W-1:0]. Zero-pad the top chunk. XOR all chunks together to form `f`.
- **MISR update** (RUN, `data_valid`=1): `sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ f`.
- **Invalid samples:** when `data_valid`=0, `sig` and all counters hold.
- **`start` in SKIP or RUN:** ignored. The run continues unchanged.
- **`sample_cnt`:** increments only on compacted samples. SKIP samples do not count. Clears on `start`. It does not wrap, because DONE is reached at or before 65535.
- **`expected_sig`:** only affects `match`. It may change at any time.

## Timing
- **Reset values:** state=IDLE, `sig`=SEED, `busy`=0, `done`=0, `match`=0, `sample_cnt`=0.
- **Reset mid-run:** the run is abandoned immediately. Every output returns to its reset value asynchronously.
- **`start` accepted at edge N:** `sig`=SEED, `busy`=1 and `sample_cnt`=0 are all visible after edge N.
- **Sample latency:** a sample valid at edge M is reflected in `sig` after edge M (1-cycle latency).
- **Run completion:** on the edge that compacts the final sample, `sig` updates, `busy` falls and `done` rises. `match` is valid in that same following cycle.
- **Hold:** `done` holds until the next accepted `start` or `rst`.
- **Throughput:** one sample per cycle with no bubbles required.

## Configuration
- **Macro:** `MISR_MASK_EN`.
- **Defined:**
  - Adds input port `mask_in` [DATA_W-1:0].
  - `data_in & mask_in` is folded instead of `data_in`.
  - Lets the harness exclude known simulator-dependent or uninitialised output bits.
- **Undefined:** the port does not exist and `data_in` is folded unmasked. Behaviour is identical to the defined case with `mask_in` all ones.

## Structure
- **Package `misr_pkg`:**
  - State enum `misr_state_e` (IDLE, SKIP, RUN, DONE).
  - Default polynomial constant `MISR_POLY32`.
  - Parameterised function `misr_step` (shift plus feedback).
- **Sub-module `misr_fold`:** purely combinational DATA_W→SIG_W XOR-fold, parameterised by DATA_W and SIG_W.

## Test plan
All scenarios use defaults unless stated (DATA_W=412, SIG_W=32, SEED=0, SKIP_CYCLES=2).

- **All-zero data:** `start`, `num_cycles`=4, 6 valid zero samples, `expected_sig`=0 → `sig`=0, `done`=1, `match`=1, `sample_cnt`=4.
- **Single bit, then shift:**
  - `num_cycles`=1, 2 skip samples, then `data_in` bit 0 set → `sig`=0x00000001.
  - Rerun with `num_cycles`=2 and a second zero sample → `sig`=0x00000002.
- **Fold wrap:** `num_cycles`=1, `data_in` bit 411 set (chunk 12, bit 27) → `sig`=0x08000000. Bit 32 set → `sig`=0x00000001.
- **Feedback:** SEED=0x80000000, SKIP_CYCLES=0, `num_cycles`=1, zero sample → `sig`=0x04C11DB7.
- **Valid gaps and restart:**
  - `data_valid` toggling 1,0,1 with the same data gives the same `sig` as two back-to-back samples.
  - `start` pulsed in RUN is ignored.
  - `rst` pulsed mid-RUN → `sig`=0, `busy`=0 immediately.
- **Mask (with `MISR_MASK_EN`):** `data_in` all ones, `mask_in`=0, `num_cycles`=3 → `sig`=0, `match`=1 with `expected_sig`=0.
